shift_arbiter: RTL and testbench

Shares one combinational 32-bit barrel shifter between two requesters (integer ALU port 0, address/immediate unit port 1) with valid/ready handshakes on both sides. Requests are arbitered round-robin, driven onto the shared shifter, and the result is captured in a single registered output slot tagged with the owner, which returns it on that requester's response channel. Sits between the issue logic and the shifter datapath; the shifter itself stays outside this block.

---
 rtl/shift_arb_pkg.sv | 22 ++
 rtl/shift_arbiter_rr_arb2.sv | 19 +
 rtl/shift_arbiter.sv | 154 +++++++++++++++
 tb/tb_shift_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_arb_pkg.sv
// Shared types and constants for the shift_arbiter block.
package shift_arb_pkg;

    localparam int XLEN    = 32;
    localparam int SHAMT_W = 5;

    localparam logic PORT_ALU = 1'b0;
    localparam logic PORT_AGU = 1'b1;

    typedef struct packed {
        logic [XLEN-1:0]    x;
        logic [SHAMT_W-1:0] shamt;
        logic               left;
        logic               arith;
    } shift_req_t;

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } slot_state_e;

endpackage

// File: rtl/shift_arbiter_rr_arb2.sv
// Two-way round-robin grant: rr_ptr wins ties, a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       rr_ptr,
    output logic       gnt_valid,
    output logic       gnt_idx
);

    // Pure combinational grant selection
    always_comb begin
        gnt_valid = |valid;
        if (valid == 2'b11) begin
            gnt_idx = rr_ptr;
        end else begin
            gnt_idx = valid[1];
        end
    end

endmodule

// File: rtl/shift_arbiter.sv
// shift_arbiter: shares one external 32-bit barrel shifter between the ALU
// (port 0) and the AGU (port 1). Round-robin arbitration, single registered
// result slot tagged with its owner.
// Optional feature: define SHIFT_ARB_STATS_EN to add per-port accept counters
// (grant_cnt0/grant_cnt1, width CNT_W).
//
// state    | meaning
// ---------+-----------------------------------------------
// ST_EMPTY | result slot holds nothing, any grant may load
// ST_FULL  | slot holds a result for slot_owner, awaiting rsp_ready
module shift_arbiter
   import shift_arb_pkg::*;
#(
   parameter int unsigned CNT_W = 16
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         req_valid,
   output logic [1:0]         req_ready,
   input  logic [XLEN-1:0]    req_x0,
   input  logic [XLEN-1:0]    req_x1,
   input  logic [SHAMT_W-1:0] req_shamt0,
   input  logic [SHAMT_W-1:0] req_shamt1,
   input  logic [1:0]         req_left,
   input  logic [1:0]         req_arith,
   output logic [1:0]         rsp_valid,
   input  logic [1:0]         rsp_ready,
   output logic [XLEN-1:0]    rsp_data,
   output logic [XLEN-1:0]    sh_x,
   output logic [SHAMT_W-1:0] sh_shift_by,
   output logic               sh_left,
   output logic               sh_arith,
   input  logic [XLEN-1:0]    sh_out
`ifdef SHIFT_ARB_STATS_EN
   ,
   output logic [CNT_W-1:0]   grant_cnt0,
   output logic [CNT_W-1:0]   grant_cnt1
`endif
);

   slot_state_e     state_q;
   slot_state_e     state_d;
   logic            slot_full;
   logic            slot_owner;
   logic [XLEN-1:0] slot_data;
   logic            rr_ptr;

   shift_req_t      req [2];
   shift_req_t      cur;
   logic            gnt_valid;
   logic            gnt_idx;
   logic            sel;
   logic            can_load;
   logic            drain;
   logic            accept;

   rr_arb2 u_rr_arb2 (
      .valid     (req_valid),
      .rr_ptr    (rr_ptr),
      .gnt_valid (gnt_valid),
      .gnt_idx   (gnt_idx)
   );

   assign slot_full = (state_q == ST_FULL);

   // Gather per-port operands and steer the selected one onto the shifter
   always_comb begin
      req[PORT_ALU] = '{x: req_x0, shamt: req_shamt0,
                        left: req_left[PORT_ALU], arith: req_arith[PORT_ALU]};
      req[PORT_AGU] = '{x: req_x1, shamt: req_shamt1,
                        left: req_left[PORT_AGU], arith: req_arith[PORT_AGU]};
      // With no grant the rr_ptr port still drives the shifter so it never sees X
      sel         = gnt_valid ? gnt_idx : rr_ptr;
      cur         = req[sel];
      sh_x        = cur.x;
      sh_shift_by = cur.shamt;
      sh_left     = cur.left;
      sh_arith    = cur.arith;
   end

   // Slot availability and acceptance; reset holds off any handshake
   always_comb begin
      drain    = slot_full & rsp_valid[slot_owner] & rsp_ready[slot_owner];
      can_load = ~slot_full | drain;
      accept   = gnt_valid & can_load & ~rst;
   end

   // FSM state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: an accept always (re)fills, a lone drain empties
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_EMPTY: if (accept) state_d = ST_FULL;
         ST_FULL: begin
            if (accept) begin
               state_d = ST_FULL;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
   end

   // FSM outputs: response valid to the owner, ready to the granted port
   always_comb begin
      rsp_valid           = 2'b00;
      rsp_valid[PORT_ALU] = slot_full & (slot_owner == PORT_ALU);
      rsp_valid[PORT_AGU] = slot_full & (slot_owner == PORT_AGU);
      req_ready           = 2'b00;
      req_ready[gnt_idx]  = accept;
   end

   assign rsp_data = slot_data;

   // Result slot and round-robin pointer; priority moves only on accept
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         slot_data  <= '0;
         slot_owner <= PORT_ALU;
         rr_ptr     <= PORT_ALU;
      end else if (accept) begin
         slot_data  <= sh_out;
         slot_owner <= gnt_idx;
         rr_ptr     <= ~gnt_idx;
      end
   end

`ifdef SHIFT_ARB_STATS_EN
   // Per-port accept counters, wrapping naturally at 2^CNT_W
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         grant_cnt0 <= '0;
         grant_cnt1 <= '0;
      end else if (accept) begin
         if (gnt_idx == PORT_ALU) begin
            grant_cnt0 <= grant_cnt0 + CNT_W'(1);
         end else begin
            grant_cnt1 <= grant_cnt1 + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_shift_arbiter.sv
// Self-checking bench for shift_arbiter: an external shifter model, a small
// arbitration/slot model and a result scoreboard.
module tb_shift_arbiter;
   import shift_arb_pkg::*;

   localparam int CNT_W = 4;
`ifdef SHIFT_ARB_STATS_EN
   logic [CNT_W-1:0] grant_cnt0, grant_cnt1;
`endif

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [1:0]  req_valid = 2'b00, req_ready, req_left = 2'b00, req_arith = 2'b00;
   logic [1:0]  rsp_valid, rsp_ready = 2'b00;
   logic [31:0] req_x0 = '0, req_x1 = '0, rsp_data, sh_x, sh_out;
   logic [4:0]  req_shamt0 = '0, req_shamt1 = '0, sh_shift_by;
   logic        sh_left, sh_arith;

   typedef struct {
      int          port;
      logic [31:0] data;
   } exp_t;
   exp_t sb[$];

   int   n_checks = 0;
   int   n_errors = 0;
   logic m_full = 1'b0, m_owner = 1'b0, m_ptr = 1'b0;
   int   m_cnt0 = 0, m_cnt1 = 0;
   logic [1:0] last_acc = 2'b00;

   always #5 clk = ~clk;

   shift_arbiter #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_x0(req_x0), .req_x1(req_x1),
      .req_shamt0(req_shamt0), .req_shamt1(req_shamt1),
      .req_left(req_left), .req_arith(req_arith),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .sh_x(sh_x), .sh_shift_by(sh_shift_by), .sh_left(sh_left), .sh_arith(sh_arith),
      .sh_out(sh_out)
`ifdef SHIFT_ARB_STATS_EN
      , .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
   );

   function automatic logic [31:0] shift_ref(input logic [31:0] x, input logic [4:0] s,
                                             input logic left, input logic arith);
      if (left) return x << s;
      if (arith) return 32'($signed(x) >>> s);
      return x >> s;
   endfunction

   // External combinational shifter
   always_comb sh_out = shift_ref(sh_x, sh_shift_by, sh_left, sh_arith);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [31:0] port_expect(input int p);
      if (p == 0) return shift_ref(req_x0, req_shamt0, req_left[0], req_arith[0]);
      return shift_ref(req_x1, req_shamt1, req_left[1], req_arith[1]);
   endfunction

   task automatic new_op(input int p);
      logic [31:0] x;
      logic [4:0]  s;
      x = $urandom;
      s = 5'($urandom_range(0, 31));
      if (p == 0) begin req_x0 = x; req_shamt0 = s; end
      else begin req_x1 = x; req_shamt1 = s; end
      req_left[p]  = 1'($urandom_range(0, 1));
      req_arith[p] = 1'($urandom_range(0, 1));
      req_valid[p] = 1'b1;
   endtask

   // One clock: called at a negedge with inputs set, returns at the next negedge
   task automatic cycle();
      logic       gv, cl, g, sel;
      logic [1:0] exp_rdy, exp_rv, acc;
      #4;
      gv = |req_valid;
      g  = (req_valid == 2'b11) ? m_ptr : req_valid[1];
      cl = !m_full || rsp_ready[m_owner];
      exp_rdy = 2'b00;
      if (gv && cl) exp_rdy[g] = 1'b1;
      exp_rv = 2'b00;
      if (m_full) exp_rv[m_owner] = 1'b1;
      sel = gv ? g : m_ptr;
      check("req_ready", 32'(req_ready), 32'(exp_rdy));
      check("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
      check("sh_x", sh_x, sel ? req_x1 : req_x0);
      for (int p = 0; p < 2; p++) begin
         if (rsp_valid[p]) begin
            if (sb.size() == 0) begin
               check("sb_size", 32'(sb.size()), 32'd1);
            end else begin
               check("rsp_port", 32'(p), 32'(sb[0].port));
               check("rsp_data", rsp_data, sb[0].data);
               if (rsp_ready[p]) void'(sb.pop_front());
            end
         end
      end
      acc = req_valid & req_ready;
      for (int p = 0; p < 2; p++) begin
         if (acc[p]) sb.push_back('{port: p, data: port_expect(p)});
      end
      @(posedge clk);
      if (gv && cl) begin
         m_full  = 1'b1;
         m_owner = g;
         m_ptr   = ~g;
         if (g == 1'b0) m_cnt0++; else m_cnt1++;
      end else if (m_full && rsp_ready[m_owner]) begin
         m_full = 1'b0;
      end
      @(negedge clk);
`ifdef SHIFT_ARB_STATS_EN
      check("grant_cnt0", 32'(grant_cnt0), 32'(m_cnt0 % (1 << CNT_W)));
      check("grant_cnt1", 32'(grant_cnt1), 32'(m_cnt1 % (1 << CNT_W)));
`endif
      req_valid = req_valid & ~acc;
      last_acc  = acc;
   endtask

   task automatic idle(input int n);
      req_valid = 2'b00;
      rsp_ready = 2'b11;
      for (int i = 0; i < n; i++) cycle();
   endtask

   initial begin
      int exp_port;
      int c0_start, c1_start;

      // Reset: handshakes held off even with both ports requesting
      req_valid = 2'b11;
      #1;
      check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("rst_req_ready", 32'(req_ready), 32'd0);
      check("rst_rsp_data", rsp_data, 32'd0);
      req_valid = 2'b00;
      @(negedge clk);
      rst = 1'b0;

      // Both valid, always ready: alternating grants from port 0, one per cycle
      rsp_ready = 2'b11;
      exp_port = 0;
      for (int i = 0; i < 8; i++) begin
         for (int p = 0; p < 2; p++) if (!req_valid[p]) new_op(p);
         cycle();
         check("alt_grant", 32'(last_acc), exp_port ? 32'd2 : 32'd1);
         exp_port = 1 - exp_port;
      end
      idle(2);

      // Port 0 alone, arithmetic right shift
      req_x0 = 32'h8000_0010; req_shamt0 = 5'd4;
      req_left[0] = 1'b0; req_arith[0] = 1'b1;
      req_valid = 2'b01; rsp_ready = 2'b00;
      cycle();
      #1;
      check("p0_rsp_valid", 32'(rsp_valid), 32'd1);
      check("p0_rsp_data", rsp_data, 32'hF800_0001);
      rsp_ready = 2'b01;
      cycle();

      // Port 1 left by 31, response stalled three cycles while port 0 waits
      req_x1 = 32'h0000_0001; req_shamt1 = 5'd31;
      req_left[1] = 1'b1; req_arith[1] = 1'b0;
      req_valid = 2'b10; rsp_ready = 2'b00;
      cycle();
      new_op(0);
      req_valid[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("stall_ready", 32'(last_acc), 32'd0);
         check("stall_data", rsp_data, 32'h8000_0000);
      end
      rsp_ready = 2'b10;
      cycle();
      check("after_stall_grant", 32'(last_acc), 32'd1);

      // Drain port 0 and refill from port 1 on the same edge
      req_valid = 2'b10;
      rsp_ready = 2'b01;
      cycle();
      check("refill_acc", 32'(last_acc), 32'd2);
      #1;
      check("refill_rsp_valid", 32'(rsp_valid), 32'd2);
      idle(2);

      // Async reset with the slot full and priority on port 1
      new_op(0);
      req_valid = 2'b01; rsp_ready = 2'b00;
      cycle();
      req_valid = 2'b11;
      #2 rst = 1'b1;
      #1;
      check("arst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("arst_req_ready", 32'(req_ready), 32'd0);
      m_full = 1'b0; m_owner = 1'b0; m_ptr = 1'b0; m_cnt0 = 0; m_cnt1 = 0;
      sb.delete();
      req_valid = 2'b00;
      @(negedge clk);
      rst = 1'b0;
      idle(2);
      new_op(0); new_op(1);
      rsp_ready = 2'b11;
      cycle();
      check("arst_ptr_grant", 32'(last_acc), 32'd1);
      idle(3);

      // Random traffic with held requests and random backpressure
      for (int i = 0; i < 300; i++) begin
         for (int p = 0; p < 2; p++)
            if (!req_valid[p] && $urandom_range(0, 2) != 0) new_op(p);
         rsp_ready = 2'($urandom_range(0, 3));
         cycle();
      end
      for (int i = 0; i < 6; i++) begin
         rsp_ready = 2'b11;
         cycle();
      end
      idle(2);

`ifdef SHIFT_ARB_STATS_EN
      // 17 port-0 accepts wrap a 4-bit counter
      c0_start = m_cnt0 % 16;
      c1_start = m_cnt1 % 16;
      for (int i = 0; i < 17; i++) begin
         new_op(0);
         req_valid = 2'b01; rsp_ready = 2'b11;
         cycle();
      end
      check("cnt0_wrap", 32'(grant_cnt0), 32'((c0_start + 17) % 16));
      check("cnt1_hold", 32'(grant_cnt1), 32'(c1_start));
      idle(2);
`else
      c0_start = 0;
      c1_start = 0;
`endif

      check("sb_drained", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
